modn_updown_counter: RTL and testbench

Parametrised modulo-N synchronous counter: generalises the team's fixed 4-bit up-counter into WIDTH/MODULUS configurable up/down counting with synchronous load, clear, enable, terminal-count and wrap flags, and a one-shot mode governed by a small state machine. It sits beside the existing counter as the general timebase/sequence-index block for timers, prescalers and address generators.

---
 rtl/counter_pkg.sv | 16 +
 rtl/modn_next.sv | 32 +++
 rtl/modn_updown_counter.sv | 129 ++++++++++++
 tb/tb_modn_updown_counter.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the counter family: FSM state encoding and
// counting-mode constants reused by present and future counter variants.
package counter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic {
    MODE_FREE    = 1'b0,
    MODE_ONESHOT = 1'b1
  } mode_e;

endpackage

// File: rtl/modn_next.sv
// Combinational modulo-N successor: next count in the chosen direction,
// terminal-count flag and wrap flag, all kept to WIDTH bits.
module modn_next #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 15
) (
  input  logic [WIDTH-1:0] q,
  input  logic             up,
  output logic [WIDTH-1:0] nxt,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 1);

  logic at_max;
  logic at_zero;

  assign at_max  = (q == MAXV);
  assign at_zero = (q == '0);

  // When MODULUS == 2**WIDTH, MAXV is all ones and q+1 overflows to zero anyway.
  always_comb begin
    nxt = q;
    if (up) nxt = at_max  ? '0   : q + WIDTH'(1);
    else    nxt = at_zero ? MAXV : q - WIDTH'(1);
  end

  assign tc   = up ? at_max : at_zero;
  assign wrap = tc;

endmodule

// File: rtl/modn_updown_counter.sv
// Parametrised modulo-N up/down counter with load, clear, enable, wrap flag
// and a one-shot mode sequenced by an IDLE/RUN/DONE state machine.
module modn_updown_counter
  import counter_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MODULUS   = 15,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             oneshot,
  input  logic             start,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             done,
  output logic             busy
);

  localparam logic [WIDTH-1:0] MAXV    = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_V   = WIDTH'(RESET_VAL);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  if (MODULUS < 2 || MODULUS > 2 ** WIDTH) begin : g_bad_modulus
    $error("modn_updown_counter: MODULUS out of range 2..2**WIDTH");
  end
  if (RESET_VAL < 0 || RESET_VAL >= MODULUS) begin : g_bad_reset_val
    $error("modn_updown_counter: RESET_VAL must lie in 0..MODULUS-1");
  end

  // Extra top bit keeps MODULUS == 2**WIDTH from truncating to zero.
  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
    if ({1'b0, v} >= MOD_EXT) return MAXV;
    return v;
  endfunction

  logic [WIDTH-1:0] cnt_p0, cnt_d;
  state_e           state_p0, state_d;
  mode_e            mode_p0, mode_d;
  logic             wrap_p0, wrap_d;
  logic             done_p0, done_d;

  logic [WIDTH-1:0] nxt;
  logic             nxt_tc;
  logic             nxt_wrap;

  modn_next #(
    .WIDTH  (WIDTH),
    .MODULUS(MODULUS)
  ) u_next (
    .q   (cnt_p0),
    .up  (up),
    .nxt (nxt),
    .tc  (nxt_tc),
    .wrap(nxt_wrap)
  );

  always_comb begin
    state_d = state_p0;
    cnt_d   = cnt_p0;
    wrap_d  = 1'b0;
    done_d  = 1'b0;
    mode_d  = (state_p0 == IDLE) ? mode_e'(oneshot) : mode_p0;
    if (clr) begin
      cnt_d   = RST_V;
      state_d = IDLE;
    end else if (load) begin
      cnt_d = clamp_load(load_val);
    end else begin
      unique case (state_p0)
        IDLE: begin
          if (mode_p0 == MODE_FREE) begin
            if (en) begin
              cnt_d  = nxt;
              wrap_d = nxt_wrap;
            end
          end else if (start) begin
            state_d = RUN;
          end
        end
        RUN: begin
          // Reaching the terminal value ends the run instead of wrapping.
          if (en) begin
            if (nxt_tc) begin
              done_d  = 1'b1;
              state_d = DONE;
            end else begin
              cnt_d = nxt;
            end
          end
        end
        DONE: begin
          if (start) state_d = RUN;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Stage p0: count, FSM state and one-cycle flag registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_p0   <= RST_V;
      state_p0 <= IDLE;
      mode_p0  <= MODE_FREE;
      wrap_p0  <= 1'b0;
      done_p0  <= 1'b0;
    end else begin
      cnt_p0   <= cnt_d;
      state_p0 <= state_d;
      mode_p0  <= mode_d;
      wrap_p0  <= wrap_d;
      done_p0  <= done_d;
    end
  end

  assign q    = cnt_p0;
  assign tc   = nxt_tc;
  assign wrap = wrap_p0;
  assign done = done_p0;
  assign busy = (state_p0 == RUN);

endmodule

// File: tb/tb_modn_updown_counter.sv
// Bench for modn_updown_counter: a MODULUS=15 and a MODULUS=16 instance share
// stimulus and are compared every cycle against an arithmetic reference model.
module tb_modn_updown_counter;

  logic       clk = 1'b0;
  logic       rst, clr, en, up, load, oneshot, start;
  logic [3:0] load_val;

  logic [3:0] qa, qb;
  logic       tca, tcb, wrapa, wrapb, donea, doneb, busya, busyb;

  int vectors     = 0;
  int miscompares = 0;

  localparam int S_IDLE = 0;
  localparam int S_RUN  = 1;
  localparam int S_DONE = 2;

  int modv[2] = '{15, 16};
  int rv[2]   = '{0, 3};
  int mq[2], mst[2], mmode[2], mwrap[2], mdone[2];

  modn_updown_counter #(.WIDTH(4), .MODULUS(15), .RESET_VAL(0)) dut_a (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .up(up), .load(load),
    .load_val(load_val), .oneshot(oneshot), .start(start),
    .q(qa), .tc(tca), .wrap(wrapa), .done(donea), .busy(busya)
  );

  modn_updown_counter #(.WIDTH(4), .MODULUS(16), .RESET_VAL(3)) dut_b (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .up(up), .load(load),
    .load_val(load_val), .oneshot(oneshot), .start(start),
    .q(qb), .tc(tcb), .wrap(wrapb), .done(doneb), .busy(busyb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mq[i] = rv[i]; mst[i] = S_IDLE; mmode[i] = 0; mwrap[i] = 0; mdone[i] = 0;
    end
  endtask

  // One clock edge of the behaviour, from the current inputs.
  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      int nmode, step, m;
      m      = modv[i];
      nmode  = (mst[i] == S_IDLE) ? int'(oneshot) : mmode[i];
      step   = up ? 1 : -1;
      mwrap[i] = 0;
      mdone[i] = 0;
      if (clr) begin
        mq[i] = rv[i]; mst[i] = S_IDLE;
      end else if (load) begin
        mq[i] = (int'(load_val) >= m) ? m - 1 : int'(load_val);
      end else if (mst[i] == S_IDLE) begin
        if (mmode[i] == 0) begin
          if (en) begin
            mwrap[i] = (mq[i] + step < 0 || mq[i] + step >= m) ? 1 : 0;
            mq[i]    = (mq[i] + step + m) % m;
          end
        end else if (start) mst[i] = S_RUN;
      end else if (mst[i] == S_RUN) begin
        if (en) begin
          if (mq[i] + step < 0 || mq[i] + step >= m) begin
            mdone[i] = 1; mst[i] = S_DONE;
          end else mq[i] = mq[i] + step;
        end
      end else begin
        if (start) mst[i] = S_RUN;
      end
      mmode[i] = nmode;
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      int etc;
      etc = up ? int'(mq[i] == modv[i] - 1) : int'(mq[i] == 0);
      chk($sformatf("q[%0d]", i),    32'(i == 0 ? qa    : qb),    32'(mq[i]));
      chk($sformatf("tc[%0d]", i),   32'(i == 0 ? tca   : tcb),   32'(etc));
      chk($sformatf("wrap[%0d]", i), 32'(i == 0 ? wrapa : wrapb), 32'(mwrap[i]));
      chk($sformatf("done[%0d]", i), 32'(i == 0 ? donea : doneb), 32'(mdone[i]));
      chk($sformatf("busy[%0d]", i), 32'(i == 0 ? busya : busyb), 32'(mst[i] == S_RUN));
    end
  endtask

  task automatic step(input logic c, input logic l, input logic [3:0] lv,
                      input logic e, input logic u, input logic o, input logic s);
    clr = c; load = l; load_val = lv; en = e; up = u; oneshot = o; start = s;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  // Reset asserted between edges: outputs must return to reset values at once.
  task automatic rst_mid();
    #2 rst = 1'b1;
    #1 model_reset();
    check_all();
    @(negedge clk);
    rst = 1'b0;
    check_all();
  endtask

  initial begin
    rst = 1'b1; clr = 0; load = 0; load_val = '0; en = 0; up = 1; oneshot = 0; start = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_all();
    chk("reset_q_a", 32'(qa), 32'd0);
    chk("reset_q_b", 32'(qb), 32'd3);

    // Free-running up through a full period and beyond
    for (int k = 0; k < 17; k++) step(0, 0, 0, 1, 1, 0, 0);
    chk("up_after17_a", 32'(qa), 32'd2);

    // Free-running down from zero
    step(1, 0, 0, 0, 1, 0, 0);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 1, 0, 0, 0);
    chk("down_a", 32'(qa), 32'd12);

    // Load beats count; oversize load clamps
    step(0, 1, 4'd9, 1, 1, 0, 0);
    chk("load9_a", 32'(qa), 32'd9);
    step(0, 1, 4'd15, 1, 1, 0, 0);
    chk("load15_a", 32'(qa), 32'd14);
    chk("load15_b", 32'(qb), 32'd15);

    // One-shot up run from 12
    step(0, 0, 0, 0, 1, 1, 0);
    step(0, 1, 4'd12, 0, 1, 1, 0);
    step(0, 0, 0, 1, 1, 1, 1);
    chk("busy_after_start_a", 32'(busya), 32'd1);
    for (int k = 0; k < 5; k++) step(0, 0, 0, 1, 1, 1, 0);
    chk("oneshot_hold_a", 32'(qa), 32'd14);
    step(1, 0, 0, 0, 1, 1, 0);
    chk("clr_busy_a", 32'(busya), 32'd0);

    // Async reset mid-run, then free counting without done
    step(0, 1, 4'd2, 0, 1, 1, 0);
    step(0, 0, 0, 1, 1, 1, 1);
    step(0, 0, 0, 1, 1, 0, 0);
    rst_mid();
    for (int k = 0; k < 4; k++) step(0, 0, 0, 1, 1, 0, 0);

    // Enable low holds q and suppresses wrap
    for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 1, 0, 0);

    // Randomised traffic
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 99) == 0) rst_mid();
      else step($urandom_range(0, 24) == 0, $urandom_range(0, 11) == 0,
                4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0,
                $urandom_range(0, 5) != 0 ? up : ~up,
                $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
